// File: rtl/approx_err_monitor_if.sv
`default_nettype none
// ============================================================================
// approx_err_monitor_if : operand/product stream into the error monitor
// Revision 1.0
// ============================================================================
interface approx_err_monitor_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod8;

    modport master (output in_valid, output a, output b, output prod8, input in_ready);
    modport slave  (input in_valid, input a, input b, input prod8, output in_ready);
endinterface
`default_nettype wire

// File: rtl/approx_err_monitor.sv
`default_nettype none
// ============================================================================
// approx_err_monitor : error statistics of an approximate 8x8 multiplier run
// Revision 1.0
// ============================================================================
module approx_err_monitor #(
    parameter int N_SAMPLES = 256,
    parameter int SUM_W     = 32,
    parameter int CNT_W     = 16
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    input  wire logic           start,
    approx_err_monitor_if.slave in_bus,
    output logic                busy,
    output logic                done,
    output logic [SUM_W-1:0]    sum_abs_err,
    output logic [SUM_W:0]      bias_sum,
    output logic [15:0]         max_abs_err,
    output logic [CNT_W-1:0]    err_count
);
    // Saturation sum needs room for both the accumulator and a 16-bit |err| plus carry
    localparam int               c_EXT_W = ((SUM_W > 16) ? SUM_W : 16) + 1;
    localparam logic [CNT_W-1:0] c_N     = CNT_W'(N_SAMPLES);
    localparam logic [CNT_W-1:0] c_LAST  = CNT_W'(N_SAMPLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic [CNT_W-1:0]   r_acc_cnt;
    logic               r_done;
    logic               w_ready, w_accept, w_last, w_clear, w_busy;
    logic               r_s1_valid;
    logic [15:0]        r_s1_exact, r_s1_prod;
    logic               r_s2_valid, r_s2_neq;
    logic signed [16:0] r_s2_diff;
    logic [15:0]        r_s2_absd;
    logic signed [16:0] w_diff;
    logic [15:0]        w_absd;
    logic [c_EXT_W-1:0] w_sum_ext;

    assign w_ready         = (r_state == S_RUN) && (r_acc_cnt < c_N);
    assign in_bus.in_ready = w_ready;
    assign w_accept        = in_bus.in_valid && w_ready;
    assign w_last          = w_accept && (r_acc_cnt == c_LAST);
    assign w_clear         = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign busy            = w_busy;
    assign done            = r_done;

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                // S1 already empty: the pair in S2 accumulates on this edge
                if (!r_s1_valid) w_state_nxt = S_DONE;
            end
            S_DONE:  if (start) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == S_DRAIN) && (w_state_nxt == S_DONE);
        end
    end

    assign w_diff = $signed({1'b0, r_s1_exact}) - $signed({1'b0, r_s1_prod});
    assign w_absd = w_diff[16] ? 16'(-w_diff) : w_diff[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_cnt  <= '0;
            r_s1_valid <= 1'b0;
            r_s1_exact <= '0;
            r_s1_prod  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_diff  <= '0;
            r_s2_absd  <= '0;
            r_s2_neq   <= 1'b0;
        end else if (w_clear) begin
            r_acc_cnt  <= '0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_acc_cnt  <= r_acc_cnt + 1'b1;
                r_s1_exact <= 16'(in_bus.a) * 16'(in_bus.b);
                r_s1_prod  <= in_bus.prod8;
            end
            r_s1_valid <= w_accept;
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_diff <= w_diff;
                r_s2_absd <= w_absd;
                r_s2_neq  <= (w_absd != 16'd0);
            end
        end
    end

    assign w_sum_ext = c_EXT_W'(sum_abs_err) + c_EXT_W'(r_s2_absd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_abs_err <= '0;
            bias_sum    <= '0;
            max_abs_err <= '0;
            err_count   <= '0;
        end else if (w_clear) begin
            sum_abs_err <= '0;
            bias_sum    <= '0;
            max_abs_err <= '0;
            err_count   <= '0;
        end else if (r_s2_valid) begin
            if (|w_sum_ext[c_EXT_W-1:SUM_W]) sum_abs_err <= '1;
            else                             sum_abs_err <= w_sum_ext[SUM_W-1:0];
            bias_sum  <= bias_sum + (SUM_W+1)'(r_s2_diff);
            if (r_s2_absd > max_abs_err) max_abs_err <= r_s2_absd;
            err_count <= err_count + CNT_W'(r_s2_neq);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_approx_err_monitor.sv
`default_nettype none
// Bench for approx_err_monitor: five instances with different run lengths/widths,
// directed table entries plus randomized runs against a queue-based model.
module tb_approx_err_monitor;
    localparam int c_NI = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [c_NI-1:0] start_v;
    logic            drv_valid;
    logic [7:0]      drv_a, drv_b;
    logic [15:0]     drv_prod;

    logic [c_NI-1:0] rdy, busy_v, done_v;
    logic [32:0]     sum_v  [c_NI];
    logic [32:0]     bias_v [c_NI];
    logic [15:0]     max_v  [c_NI];
    logic [15:0]     cnt_v  [c_NI];

    approx_err_monitor_if ifc [c_NI] ();

    for (genvar g = 0; g < c_NI; g++) begin : g_drv
        assign ifc[g].in_valid = drv_valid;
        assign ifc[g].a        = drv_a;
        assign ifc[g].b        = drv_b;
        assign ifc[g].prod8    = drv_prod;
        assign rdy[g]          = ifc[g].in_ready;
    end

    function automatic int n_of(input int k);
        case (k)
            0:       return 256;
            1:       return 1;
            2:       return 2;
            default: return 16;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        logic [31:0] s;
        logic [32:0] bi;
        approx_err_monitor #(.N_SAMPLES(n_of(g)), .SUM_W(32), .CNT_W(16)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start_v[g]), .in_bus(ifc[g].slave),
            .busy(busy_v[g]), .done(done_v[g]), .sum_abs_err(s), .bias_sum(bi),
            .max_abs_err(max_v[g]), .err_count(cnt_v[g]));
        assign sum_v[g]  = {1'b0, s};
        assign bias_v[g] = bi;
    end

    logic [7:0] s4;
    logic [8:0] b4;
    approx_err_monitor #(.N_SAMPLES(300), .SUM_W(8), .CNT_W(16)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start_v[4]), .in_bus(ifc[4].slave),
        .busy(busy_v[4]), .done(done_v[4]), .sum_abs_err(s4), .bias_sum(b4),
        .max_abs_err(max_v[4]), .err_count(cnt_v[4]));
    assign sum_v[4]  = {25'd0, s4};
    assign bias_v[4] = {24'd0, b4};

    int checks = 0;
    int errors = 0;
    int pa[$], pb[$], pp[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic gen_pairs(input int gen);
        int a, b, p;
        pa.delete(); pb.delete(); pp.delete();
        case (gen)
            0: for (int i = 0; i < 256; i++) begin
                pa.push_back(i); pb.push_back(255 - i); pp.push_back(i * (255 - i));
            end
            1: begin pa.push_back(255); pb.push_back(255); pp.push_back(16'hFE00); end
            2: begin
                pa.push_back(3); pb.push_back(5); pp.push_back(17);
                pa.push_back(4); pb.push_back(4); pp.push_back(16);
            end
            3: for (int i = 0; i < 300; i++) begin
                a = int'($urandom_range(255, 1)); b = int'($urandom_range(255, 1));
                pa.push_back(a); pb.push_back(b); pp.push_back(a * b - 1);
            end
            4: for (int i = 0; i < 16; i++) begin
                a = int'($urandom_range(255)); b = int'($urandom_range(255));
                case ($urandom_range(2))
                    0:       p = a * b;
                    1:       p = a * b + int'($urandom_range(40)) - 20;
                    default: p = int'($urandom_range(65535));
                endcase
                if (p < 0) p = 0;
                if (p > 65535) p = 65535;
                pa.push_back(a); pb.push_back(b); pp.push_back(p);
            end
            default: for (int i = 0; i < 16; i++) begin
                a = int'($urandom_range(255)); b = int'($urandom_range(255));
                pa.push_back(a); pb.push_back(b); pp.push_back((a * b) ^ 1);
            end
        endcase
    endtask

    // Expected statistics straight from the definitions over the whole pair list
    task automatic model(input int sw, output logic [63:0] es, output logic [63:0] eb,
                         output logic [63:0] em, output logic [63:0] ec);
        longint sat, s, bs, m, c, e, ae;
        sat = (longint'(1) <<< sw) - 1;
        s = 0; bs = 0; m = 0; c = 0;
        foreach (pa[i]) begin
            e  = longint'(pa[i] * pb[i] - pp[i]);
            ae = (e < 0) ? -e : e;
            s  = (s + ae > sat) ? sat : s + ae;
            bs += e;
            if (ae > m) m = ae;
            if (e != 0) c++;
        end
        es = 64'(s);
        eb = 64'(bs & ((longint'(1) <<< (sw + 1)) - 1));
        em = 64'(m);
        ec = 64'(c);
    endtask

    task automatic run(input int sel, input int gap, input int restart_at, input string tag,
                       input logic [63:0] es, input logic [63:0] eb,
                       input logic [63:0] em, input logic [63:0] ec);
        int  n, idx, cyc, lat, early_done, extra_done;
        bit  acc, bad_rdy;
        logic [32:0] held;
        n = pa.size(); idx = 0; cyc = 0; early_done = 0; extra_done = 0; bad_rdy = 0;
        @(posedge clk); #1;
        start_v[sel] = 1'b1;
        @(posedge clk); #1;
        start_v[sel] = 1'b0;
        chk($sformatf("%s_busy_start", tag), 64'(busy_v[sel]), 64'd1);
        chk($sformatf("%s_sum_cleared", tag), 64'(sum_v[sel]), 64'd0);
        while (idx < n && cyc < 5000) begin
            drv_valid    = ($urandom_range(99) >= gap);
            drv_a        = drv_valid ? 8'(pa[idx]) : 8'($urandom);
            drv_b        = drv_valid ? 8'(pb[idx]) : 8'($urandom);
            drv_prod     = drv_valid ? 16'(pp[idx]) : 16'($urandom);
            start_v[sel] = (restart_at >= 0 && idx == restart_at);
            if (!rdy[sel]) bad_rdy = 1'b1;
            acc = drv_valid && rdy[sel];
            @(posedge clk); #1;
            if (done_v[sel]) early_done++;
            if (acc) idx++;
            cyc++;
        end
        drv_valid = 1'b0; start_v[sel] = 1'b0;
        chk($sformatf("%s_accepted", tag), 64'(idx), 64'(n));
        chk($sformatf("%s_ready_in_run", tag), 64'(bad_rdy), 64'd0);
        chk($sformatf("%s_ready_drop", tag), 64'(rdy[sel]), 64'd0);
        chk($sformatf("%s_busy_drain", tag), 64'(busy_v[sel]), 64'd1);
        chk($sformatf("%s_early_done", tag), 64'(early_done), 64'd0);
        if (gap == 0) chk($sformatf("%s_throughput_cycles", tag), 64'(cyc), 64'(n));
        lat = 0;
        while (!done_v[sel] && lat < 20) begin @(posedge clk); #1; lat++; end
        chk($sformatf("%s_done_latency", tag), 64'(lat), 64'd2);
        chk($sformatf("%s_sum", tag), 64'(sum_v[sel]), es);
        chk($sformatf("%s_bias", tag), 64'(bias_v[sel]), eb);
        chk($sformatf("%s_max", tag), 64'(max_v[sel]), em);
        chk($sformatf("%s_errcnt", tag), 64'(cnt_v[sel]), ec);
        chk($sformatf("%s_busy_done", tag), 64'(busy_v[sel]), 64'd0);
        held = sum_v[sel];
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (done_v[sel]) extra_done++;
        end
        chk($sformatf("%s_done_once", tag), 64'(extra_done), 64'd0);
        chk($sformatf("%s_sum_held", tag), 64'(sum_v[sel]), 64'(held));
    endtask

    typedef struct {
        int          sel;
        int          gen;
        int          gap;
        int          restart;
        int          sw;
        bit          use_model;
        logic [63:0] e_sum, e_bias, e_max, e_cnt;
        string       tag;
    } tcase_t;

    tcase_t tc [6];

    initial begin
        logic [63:0] es, eb, em, ec;
        int nd;
        tc[0] = '{0, 0, 0,  -1, 32, 1'b0, 64'd0,   64'd0,              64'd0, 64'd0,   "exact256"};
        tc[1] = '{1, 1, 0,  -1, 32, 1'b0, 64'd1,   64'd1,              64'd1, 64'd1,   "single"};
        tc[2] = '{2, 2, 30, -1, 32, 1'b0, 64'd2,   64'h1_FFFF_FFFE,    64'd2, 64'd1,   "two_pairs"};
        tc[3] = '{3, 4, 50, -1, 32, 1'b1, 64'd0,   64'd0,              64'd0, 64'd0,   "rand16"};
        tc[4] = '{3, 4, 50, 7,  32, 1'b1, 64'd0,   64'd0,              64'd0, 64'd0,   "rand16_midstart"};
        tc[5] = '{4, 3, 20, -1, 8,  1'b0, 64'd255, 64'd300,            64'd1, 64'd300, "sat300"};

        rst_n = 1'b0; start_v = '0; drv_valid = 1'b0;
        drv_a = '0; drv_b = '0; drv_prod = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy_v), 64'd0);
        chk("reset_done", 64'(done_v), 64'd0);
        chk("reset_ready", 64'(rdy), 64'd0);
        chk("reset_sum", 64'(sum_v[0]), 64'd0);
        chk("reset_errcnt", 64'(cnt_v[0]), 64'd0);
        rst_n = 1'b1;

        for (int t = 0; t < 6; t++) begin
            gen_pairs(tc[t].gen);
            if (tc[t].use_model) model(tc[t].sw, es, eb, em, ec);
            else begin es = tc[t].e_sum; eb = tc[t].e_bias; em = tc[t].e_max; ec = tc[t].e_cnt; end
            run(tc[t].sel, tc[t].gap, tc[t].restart, tc[t].tag, es, eb, em, ec);
        end

        // Abort mid-run: five accepted erroneous pairs, then asynchronous reset
        gen_pairs(5);
        @(posedge clk); #1;
        start_v[3] = 1'b1;
        @(posedge clk); #1;
        start_v[3] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drv_valid = 1'b1; drv_a = 8'(pa[k]); drv_b = 8'(pb[k]); drv_prod = 16'(pp[k]);
            @(posedge clk); #1;
        end
        drv_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("abort_pre_sum", 64'(sum_v[3]), 64'd5);
        chk("abort_pre_errcnt", 64'(cnt_v[3]), 64'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy_v[3]), 64'd0);
        chk("abort_ready", 64'(rdy[3]), 64'd0);
        chk("abort_sum", 64'(sum_v[3]), 64'd0);
        chk("abort_bias", 64'(bias_v[3]), 64'd0);
        chk("abort_max", 64'(max_v[3]), 64'd0);
        chk("abort_errcnt", 64'(cnt_v[3]), 64'd0);
        #20 rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done_v[3]) nd++;
        end
        chk("abort_no_done", 64'(nd), 64'd0);
        chk("abort_idle_ready", 64'(rdy[3]), 64'd0);
        chk("abort_idle_busy", 64'(busy_v[3]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
